// File: rtl/mxu_wb_pack.sv
// ---------------------------------------------------------------------------
// mxu_wb_pack
//
// Collects a run of MXU result bytes into one 128-bit line and writes the line
// back with per-byte strobes. A command names the line address and a first and
// a last byte lane. Bytes fill the lanes one at a time, going up or down from
// the first lane. When the last lane is filled, the packed line is offered on
// the write port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_vld/cmd_rdy     command handshake (accepted only in IDLE)
//   cmd_addr            destination line address
//   cmd_start_byte      first byte lane to fill
//   cmd_end_byte        last byte lane to fill
//   mxu_vld/mxu_rdy     result byte handshake (accepted only in FILL)
//   mxu_byte            result byte
//   wr_vld/wr_rdy       line write handshake (offered only in SEND)
//   wr_addr             line address of the write
//   wr_data             packed line; lane i = bits [8i+7:8i]
//   wr_strb             byte-lane enables; bit i qualifies lane i
//   wr_done             one-cycle pulse after each completed write
// ---------------------------------------------------------------------------
module mxu_wb_pack #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [3:0]            cmd_start_byte,
    input  logic [3:0]            cmd_end_byte,
    input  logic                  mxu_vld,
    input  logic [7:0]            mxu_byte,
    output logic                  mxu_rdy,
    output logic                  wr_vld,
    input  logic                  wr_rdy,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W/8-1:0]   wr_strb,
    output logic                  wr_done
);

    localparam int LANES = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [3:0]        end_q,   end_d;
    logic              desc_q,  desc_d;
    logic [3:0]        cur_q,   cur_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [LANES-1:0]  strb_q,  strb_d;
    logic              done_q,  done_d;

    logic              byte_hs;
    logic [LANES-1:0]  lane_wr;
    logic [DATA_W-1:0] data_fill;
    logic [LANES-1:0]  strb_fill;

    assign byte_hs = mxu_vld && (state_q == ST_FILL);

    // Per-lane merge of the incoming byte: only the lane addressed by cur_q
    // takes the new byte and raises its strobe; all other lanes hold.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_wr[gi]            = byte_hs && (cur_q == 4'(gi));
            assign data_fill[8*gi +: 8]   = lane_wr[gi] ? mxu_byte : data_q[8*gi +: 8];
            assign strb_fill[gi]          = strb_q[gi] | lane_wr[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        desc_d  = desc_q;
        cur_d   = cur_q;
        data_d  = data_q;
        strb_d  = strb_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    addr_d  = cmd_addr;
                    end_d   = cmd_end_byte;
                    // Direction is frozen here so cur_q walks toward end_q and
                    // meets it before it could ever wrap past lane 0 or 15.
                    desc_d  = (cmd_start_byte > cmd_end_byte);
                    cur_d   = cmd_start_byte;
                    data_d  = '0;
                    strb_d  = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mxu_vld) begin
                    data_d = data_fill;
                    strb_d = strb_fill;
                    if (cur_q == end_q) begin
                        state_d = ST_SEND;
                    end else if (desc_q) begin
                        cur_d = cur_q - 4'd1;
                    end else begin
                        cur_d = cur_q + 4'd1;
                    end
                end
            end
            ST_SEND: begin
                if (wr_rdy) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            desc_q  <= 1'b0;
            cur_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            desc_q  <= desc_d;
            cur_q   <= cur_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            done_q  <= done_d;
        end
    end

    assign cmd_rdy = (state_q == ST_IDLE);
    assign mxu_rdy = (state_q == ST_FILL);
    assign wr_vld  = (state_q == ST_SEND);
    assign wr_addr = addr_q;
    assign wr_data = data_q;
    assign wr_strb = strb_q;
    assign wr_done = done_q;

endmodule

// File: tb/tb_mxu_wb_pack.sv
// ---------------------------------------------------------------------------
// tb_mxu_wb_pack
//
// Directed bench for mxu_wb_pack. Each test task drives one scenario and
// compares captured write-port values against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mxu_wb_pack;

    logic         clk;
    logic         rst;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic [7:0]   cmd_addr;
    logic [3:0]   cmd_start_byte;
    logic [3:0]   cmd_end_byte;
    logic         mxu_vld;
    logic [7:0]   mxu_byte;
    logic         mxu_rdy;
    logic         wr_vld;
    logic         wr_rdy;
    logic [7:0]   wr_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_strb;
    logic         wr_done;

    int asserts = 0;
    int fails   = 0;

    mxu_wb_pack #(.ADDR_W(8), .DATA_W(128)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_vld        (cmd_vld),
        .cmd_rdy        (cmd_rdy),
        .cmd_addr       (cmd_addr),
        .cmd_start_byte (cmd_start_byte),
        .cmd_end_byte   (cmd_end_byte),
        .mxu_vld        (mxu_vld),
        .mxu_byte       (mxu_byte),
        .mxu_rdy        (mxu_rdy),
        .wr_vld         (wr_vld),
        .wr_rdy         (wr_rdy),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_strb        (wr_strb),
        .wr_done        (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one command: issues it, streams nb bytes (optionally only on odd
    // cycles), holds wr_rdy low for 'stall' cycles, then completes the write.
    // With ign set, junk commands and bytes are driven where they must be ignored.
    task automatic do_xfer(
        input  logic [7:0]   a,
        input  logic [3:0]   s,
        input  logic [3:0]   e,
        input  logic [127:0] bytes,
        input  int           nb,
        input  bit           gaps,
        input  int           stall,
        input  bit           ign,
        output logic [7:0]   ca,
        output logic [127:0] cd,
        output logic [15:0]  cs,
        output int           lat,
        output int           nhs,
        output bit           rdy_ok,
        output bit           stable_ok,
        output bit           done_ok,
        output bit           tmo
    );
        int cyc;
        int i;
        bit hs;
        rdy_ok = 1; stable_ok = 1; done_ok = 1; tmo = 0;
        lat = 0; ca = '0; cd = '0; cs = '0;
        cmd_vld = 1'b1; cmd_addr = a; cmd_start_byte = s; cmd_end_byte = e;
        if (cmd_rdy !== 1'b1) rdy_ok = 0;
        @(posedge clk); #1;
        cyc = 1; i = 0;
        cmd_vld = ign; cmd_addr = 8'hFF; cmd_start_byte = 4'h0; cmd_end_byte = 4'hF;
        while (wr_vld !== 1'b1 && cyc < 200) begin
            if (cmd_rdy !== 1'b0) rdy_ok = 0;
            mxu_vld  = (i < nb) && !(gaps && (cyc % 2 == 0));
            mxu_byte = (i < 16) ? bytes[8*i +: 8] : 8'hEE;
            hs = mxu_vld && mxu_rdy;
            @(posedge clk); #1;
            cyc++;
            if (hs) i++;
        end
        nhs = i;
        if (wr_vld !== 1'b1) begin
            tmo = 1; mxu_vld = 0; cmd_vld = 0;
            return;
        end
        lat = cyc; ca = wr_addr; cd = wr_data; cs = wr_strb;
        mxu_vld = ign; mxu_byte = 8'hEE;
        for (int k = 0; k < stall; k++) begin
            wr_rdy = 1'b0;
            @(posedge clk); #1;
            if (wr_addr !== ca || wr_data !== cd || wr_strb !== cs || wr_vld !== 1'b1) stable_ok = 0;
            if (cmd_rdy !== 1'b0) rdy_ok = 0;
        end
        wr_rdy = 1'b1;
        if (wr_done !== 1'b0) done_ok = 0;
        @(posedge clk); #1;
        wr_rdy = 1'b0; cmd_vld = 1'b0; mxu_vld = 1'b0;
        if (wr_done !== 1'b1 || cmd_rdy !== 1'b1 || wr_vld !== 1'b0) done_ok = 0;
        @(posedge clk); #1;
        if (wr_done !== 1'b0) done_ok = 0;
        $display("xfer addr=%h start=%0d end=%0d lat=%0d bytes=%0d strb=%h data=%h", a, s, e, lat, nhs, cs, cd);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_vld = 0; mxu_vld = 0; wr_rdy = 0;
        cmd_addr = '0; cmd_start_byte = '0; cmd_end_byte = '0; mxu_byte = '0;
        repeat (2) @(posedge clk);
        #1;
        if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL rst_cmd_rdy got %b exp 1", cmd_rdy); end asserts++;
        if (mxu_rdy !== 1'b0) begin fails++; $display("FAIL rst_mxu_rdy got %b exp 0", mxu_rdy); end asserts++;
        if (wr_vld !== 1'b0) begin fails++; $display("FAIL rst_wr_vld got %b exp 0", wr_vld); end asserts++;
        if (wr_done !== 1'b0) begin fails++; $display("FAIL rst_wr_done got %b exp 0", wr_done); end asserts++;
        if (wr_data !== 128'h0 || wr_strb !== 16'h0 || wr_addr !== 8'h0) begin
            fails++; $display("FAIL rst_outputs got addr=%h strb=%h data=%h exp zeros", wr_addr, wr_strb, wr_data);
        end asserts++;
        rst = 1'b0;
        $display("reset done");
    endtask

    task automatic test_ascending();
        logic [7:0] ca; logic [127:0] cd; logic [15:0] cs;
        int lat, nhs; bit rok, sok, dok, tmo;
        do_xfer(8'h10, 4'd2, 4'd5, 128'hA4A3A2A1, 4, 0, 0, 0, ca, cd, cs, lat, nhs, rok, sok, dok, tmo);
        if (tmo !== 1'b0) begin fails++; $display("FAIL asc_timeout got %b exp 0", tmo); end asserts++;
        if (lat != 5) begin fails++; $display("FAIL asc_latency got %0d exp 5", lat); end asserts++;
        if (ca !== 8'h10) begin fails++; $display("FAIL asc_addr got %h exp 10", ca); end asserts++;
        if (cs !== 16'h003C) begin fails++; $display("FAIL asc_strb got %h exp 003c", cs); end asserts++;
        if (cd !== 128'h0000_0000_0000_0000_0000_A4A3_A2A1_0000) begin
            fails++; $display("FAIL asc_data got %h exp 0000000000000000_0000a4a3a2a10000", cd);
        end asserts++;
        if (dok !== 1'b1) begin fails++; $display("FAIL asc_wr_done got %b exp 1", dok); end asserts++;
        if (rok !== 1'b1) begin fails++; $display("FAIL asc_cmd_rdy got %b exp 1", rok); end asserts++;
    endtask

    task automatic test_descending();
        logic [7:0] ca; logic [127:0] cd; logic [15:0] cs;
        int lat, nhs; bit rok, sok, dok, tmo;
        do_xfer(8'h33, 4'd15, 4'd12, 128'h04030201, 4, 0, 0, 0, ca, cd, cs, lat, nhs, rok, sok, dok, tmo);
        if (tmo !== 1'b0) begin fails++; $display("FAIL desc_timeout got %b exp 0", tmo); end asserts++;
        if (lat != 5) begin fails++; $display("FAIL desc_latency got %0d exp 5", lat); end asserts++;
        if (cs !== 16'hF000) begin fails++; $display("FAIL desc_strb got %h exp f000", cs); end asserts++;
        if (cd !== 128'h0102_0304_0000_0000_0000_0000_0000_0000) begin
            fails++; $display("FAIL desc_data got %h exp 01020304000000000000000000000000", cd);
        end asserts++;
        if (dok !== 1'b1) begin fails++; $display("FAIL desc_wr_done got %b exp 1", dok); end asserts++;
    endtask

    task automatic test_single_and_full();
        logic [7:0] ca; logic [127:0] cd; logic [15:0] cs;
        int lat, nhs; bit rok, sok, dok, tmo;
        do_xfer(8'h07, 4'd7, 4'd7, 128'h5A, 1, 0, 0, 0, ca, cd, cs, lat, nhs, rok, sok, dok, tmo);
        if (tmo !== 1'b0) begin fails++; $display("FAIL single_timeout got %b exp 0", tmo); end asserts++;
        if (lat != 2) begin fails++; $display("FAIL single_latency got %0d exp 2", lat); end asserts++;
        if (cs !== 16'h0080) begin fails++; $display("FAIL single_strb got %h exp 0080", cs); end asserts++;
        if (cd !== 128'h0000_0000_0000_0000_5A00_0000_0000_0000) begin
            fails++; $display("FAIL single_data got %h exp 00000000000000005a00000000000000", cd);
        end asserts++;
        do_xfer(8'hC8, 4'd0, 4'd15, 128'h1F1E1D1C_1B1A1918_17161514_13121110, 16, 0, 0, 0,
                ca, cd, cs, lat, nhs, rok, sok, dok, tmo);
        if (tmo !== 1'b0) begin fails++; $display("FAIL full_timeout got %b exp 0", tmo); end asserts++;
        if (lat != 17) begin fails++; $display("FAIL full_latency got %0d exp 17", lat); end asserts++;
        if (ca !== 8'hC8) begin fails++; $display("FAIL full_addr got %h exp c8", ca); end asserts++;
        if (cs !== 16'hFFFF) begin fails++; $display("FAIL full_strb got %h exp ffff", cs); end asserts++;
        if (cd !== 128'h1F1E1D1C_1B1A1918_17161514_13121110) begin
            fails++; $display("FAIL full_data got %h exp 1f1e1d1c1b1a19181716151413121110", cd);
        end asserts++;
    endtask

    task automatic test_backpressure();
        logic [7:0] ca; logic [127:0] cd; logic [15:0] cs;
        int lat, nhs; bit rok, sok, dok, tmo;
        do_xfer(8'h5C, 4'd3, 4'd6, 128'hC3C2C1C0, 4, 1, 4, 1, ca, cd, cs, lat, nhs, rok, sok, dok, tmo);
        if (tmo !== 1'b0) begin fails++; $display("FAIL bp_timeout got %b exp 0", tmo); end asserts++;
        if (nhs != 4) begin fails++; $display("FAIL bp_byte_count got %0d exp 4", nhs); end asserts++;
        if (ca !== 8'h5C) begin fails++; $display("FAIL bp_addr got %h exp 5c", ca); end asserts++;
        if (cs !== 16'h0078) begin fails++; $display("FAIL bp_strb got %h exp 0078", cs); end asserts++;
        if (cd !== 128'h0000_0000_0000_0000_00C3_C2C1_C000_0000) begin
            fails++; $display("FAIL bp_data got %h exp 000000000000000000c3c2c1c0000000", cd);
        end asserts++;
        if (sok !== 1'b1) begin fails++; $display("FAIL bp_stable got %b exp 1", sok); end asserts++;
        if (rok !== 1'b1) begin fails++; $display("FAIL bp_cmd_rdy got %b exp 1", rok); end asserts++;
        if (dok !== 1'b1) begin fails++; $display("FAIL bp_wr_done got %b exp 1", dok); end asserts++;
    endtask

    task automatic test_reset_mid_fill();
        logic [7:0] ca; logic [127:0] cd; logic [15:0] cs;
        int lat, nhs; bit rok, sok, dok, tmo;
        cmd_vld = 1; cmd_addr = 8'h20; cmd_start_byte = 4'd0; cmd_end_byte = 4'd3;
        @(posedge clk); #1;
        cmd_vld = 0; mxu_vld = 1; mxu_byte = 8'h11;
        @(posedge clk); #1;
        mxu_byte = 8'h22;
        @(posedge clk); #1;
        // Reset collides with a live byte handshake; reset must win.
        rst = 1; mxu_byte = 8'h33;
        @(posedge clk); #1;
        rst = 0; mxu_vld = 0;
        $display("reset mid-fill after 2 bytes");
        if (cmd_rdy !== 1'b1 || mxu_rdy !== 1'b0 || wr_vld !== 1'b0 || wr_done !== 1'b0) begin
            fails++; $display("FAIL midrst_ctrl got cmd_rdy=%b mxu_rdy=%b wr_vld=%b wr_done=%b exp 1000",
                              cmd_rdy, mxu_rdy, wr_vld, wr_done);
        end asserts++;
        if (wr_data !== 128'h0 || wr_strb !== 16'h0 || wr_addr !== 8'h0) begin
            fails++; $display("FAIL midrst_outputs got addr=%h strb=%h data=%h exp zeros", wr_addr, wr_strb, wr_data);
        end asserts++;
        do_xfer(8'h21, 4'd8, 4'd9, 128'h8877, 2, 0, 0, 0, ca, cd, cs, lat, nhs, rok, sok, dok, tmo);
        if (tmo !== 1'b0) begin fails++; $display("FAIL midrst_timeout got %b exp 0", tmo); end asserts++;
        if (lat != 3) begin fails++; $display("FAIL midrst_latency got %0d exp 3", lat); end asserts++;
        if (cs !== 16'h0300) begin fails++; $display("FAIL midrst_strb got %h exp 0300", cs); end asserts++;
        if (cd !== 128'h0000_0000_0000_8877_0000_0000_0000_0000) begin
            fails++; $display("FAIL midrst_data got %h exp 00000000000088770000000000000000", cd);
        end asserts++;
        if (ca !== 8'h21) begin fails++; $display("FAIL midrst_addr got %h exp 21", ca); end asserts++;
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_single_and_full();
        test_backpressure();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
